// File: rtl/tapped_shift_reg.sv
// tapped_shift_reg: DEPTH-stage, WIDTH-bit tapped delay line with clock enable,
// synchronous clear, saturating fill counter and a run-time selectable tap whose
// validity reflects whether that stage has been written since the last reset/clear.
// Build option: define TAPPED_SHIFT_REG_OUT_REG_EN to register selected_out and
// tap_valid (one cycle of tap_sel latency, sampled on every edge regardless of CE).
module tapped_shift_reg #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int SEL_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             CLR,
    input  logic [WIDTH-1:0] Din,
    input  logic [SEL_W-1:0] tap_sel,
    output logic [WIDTH-1:0] Dout,
    output logic [WIDTH-1:0] selected_out,
    output logic             tap_valid,
    output logic [CNT_W-1:0] fill_cnt,
    output logic             full
);

    logic [WIDTH-1:0] stage_p0 [DEPTH];
    logic [CNT_W-1:0] cnt_p0;
    logic [WIDTH-1:0] tap_data;
    logic             tap_vld;

    // Delay line: clear dominates enable; on enable every stage takes its predecessor.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) stage_p0[i] <= '0;
        end else if (CLR) begin
            for (int i = 0; i < DEPTH; i++) stage_p0[i] <= '0;
        end else if (CE) begin
            stage_p0[0] <= Din;
            for (int i = 1; i < DEPTH; i++) stage_p0[i] <= stage_p0[i-1];
        end
    end

    // Fill counter: counts shifts since reset/clear, saturating once every stage is written.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_p0 <= '0;
        end else if (CLR) begin
            cnt_p0 <= '0;
        end else if (CE && (cnt_p0 != CNT_W'(DEPTH))) begin
            cnt_p0 <= cnt_p0 + 1'b1;
        end
    end

    // Tap mux: an index with no matching stage (non power-of-two DEPTH) reads as 0;
    // such an index is never below fill count, so it is also reported invalid.
    always_comb begin
        tap_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (SEL_W'(i) == tap_sel) tap_data = stage_p0[i];
        end
        tap_vld = (CNT_W'(tap_sel) < cnt_p0);
    end

`ifdef TAPPED_SHIFT_REG_OUT_REG_EN
    logic [WIDTH-1:0] tap_data_p1;
    logic             vld_p1;

    // Registered tap: samples pre-shift stage contents every edge; cleared with the line.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tap_data_p1 <= '0;
            vld_p1      <= 1'b0;
        end else if (CLR) begin
            tap_data_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            tap_data_p1 <= tap_data;
            vld_p1      <= tap_vld;
        end
    end

    assign selected_out = tap_data_p1;
    assign tap_valid    = vld_p1;
`else
    assign selected_out = tap_data;
    assign tap_valid    = tap_vld;
`endif

    assign Dout     = stage_p0[DEPTH-1];
    assign fill_cnt = cnt_p0;
    assign full     = (cnt_p0 == CNT_W'(DEPTH));

endmodule

// File: tb/tb_tapped_shift_reg.sv
// Testbench for tapped_shift_reg: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed values (WIDTH=4/DEPTH=8 and WIDTH=3/DEPTH=5).
module tb_tapped_shift_reg;
    localparam int W = 4;
    localparam int D = 8;

    logic         CLK;
    logic         RST;
    logic         CE;
    logic         CLR;
    logic [W-1:0] Din;
    logic [2:0]   tap_sel;
    logic [W-1:0] Dout;
    logic [W-1:0] selected_out;
    logic         tap_valid;
    logic [3:0]   fill_cnt;
    logic         full;

    logic         ce5;
    logic         clr5;
    logic [2:0]   din5;
    logic [2:0]   tap5;
    logic [2:0]   dout5;
    logic [2:0]   sel5;
    logic         vld5;
    logic [2:0]   cnt5;
    logic         full5;

    int checks = 0;
    int errors = 0;

    tapped_shift_reg #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .CLR(CLR), .Din(Din), .tap_sel(tap_sel),
        .Dout(Dout), .selected_out(selected_out), .tap_valid(tap_valid),
        .fill_cnt(fill_cnt), .full(full)
    );

    tapped_shift_reg #(.WIDTH(3), .DEPTH(5)) dut5 (
        .CLK(CLK), .RST(RST), .CE(ce5), .CLR(clr5), .Din(din5), .tap_sel(tap5),
        .Dout(dout5), .selected_out(sel5), .tap_valid(vld5),
        .fill_cnt(cnt5), .full(full5)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue front is the newest sample (stage 0).
    int m_q[$];
    int m_cnt;
    int m_rsel;
    int m_rvld;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_q.delete();
            repeat (D) m_q.push_back(0);
            m_cnt  = 0;
            m_rsel = 0;
            m_rvld = 0;
        end else begin
            m_rsel = (int'(tap_sel) < D) ? m_q[tap_sel] : 0;
            m_rvld = (int'(tap_sel) < m_cnt) ? 1 : 0;
            if (CLR) begin
                for (int i = 0; i < D; i++) m_q[i] = 0;
                m_cnt  = 0;
                m_rsel = 0;
                m_rvld = 0;
            end else if (CE) begin
                m_q.push_front(int'(Din));
                void'(m_q.pop_back());
                if (m_cnt < D) m_cnt++;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (m_q.size() == D) begin
            chk("m_dout", 32'(Dout), 32'(m_q[D-1]));
            chk("m_fill", 32'(fill_cnt), 32'(m_cnt));
            chk("m_full", 32'(full), (m_cnt == D) ? 32'd1 : 32'd0);
`ifdef TAPPED_SHIFT_REG_OUT_REG_EN
            chk("m_sel", 32'(selected_out), 32'(m_rsel));
            chk("m_vld", 32'(tap_valid), 32'(m_rvld));
`else
            chk("m_sel", 32'(selected_out), 32'(m_q[tap_sel]));
            chk("m_vld", 32'(tap_valid), (int'(tap_sel) < m_cnt) ? 32'd1 : 32'd0);
`endif
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic shift(input logic [W-1:0] d);
        CE  = 1'b1;
        Din = d;
        step();
        CE  = 1'b0;
    endtask

    task automatic tap_chk(input logic [2:0] s, input logic [W-1:0] ed, input logic ev, input string nm);
        CE      = 1'b0;
        tap_sel = s;
`ifdef TAPPED_SHIFT_REG_OUT_REG_EN
        step();
`endif
        #1;
        chk({nm, "_data"}, 32'(selected_out), 32'(ed));
        chk({nm, "_vld"}, 32'(tap_valid), 32'(ev));
    endtask

    task automatic tap5_chk(input logic [2:0] s, input logic [2:0] ed, input logic ev, input string nm);
        tap5 = s;
`ifdef TAPPED_SHIFT_REG_OUT_REG_EN
        step();
`endif
        #1;
        chk({nm, "_data"}, 32'(sel5), 32'(ed));
        chk({nm, "_vld"}, 32'(vld5), 32'(ev));
    endtask

    initial begin
        RST = 1'b1; CE = 1'b0; CLR = 1'b0; Din = '0; tap_sel = '0;
        ce5 = 1'b0; clr5 = 1'b0; din5 = '0; tap5 = '0;
        #1 RST = 1'b0;
        step();
        step();
        chk("rst_dout", 32'(Dout), 32'd0);
        chk("rst_fill", 32'(fill_cnt), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_sel", 32'(selected_out), 32'd0);
        chk("rst_vld", 32'(tap_valid), 32'd0);
        RST = 1'b1;

        // Fill with 1..8, then one more shift.
        for (int d = 1; d <= 8; d++) shift(W'(d));
        chk("fill8_dout", 32'(Dout), 32'd1);
        chk("fill8_cnt", 32'(fill_cnt), 32'd8);
        chk("fill8_full", 32'(full), 32'd1);
        tap_chk(3'd0, 4'd8, 1'b1, "fill8_tap0");
        tap_chk(3'd5, 4'd3, 1'b1, "fill8_tap5");
        tap_chk(3'd7, 4'd1, 1'b1, "fill8_tap7");
        shift(4'd9);
        chk("sh9_dout", 32'(Dout), 32'd2);
        chk("sh9_cnt", 32'(fill_cnt), 32'd8);

        // Clear, three shifts, sweep all taps.
        CLR = 1'b1; step(); CLR = 1'b0;
        shift(4'hA); shift(4'hB); shift(4'hC);
        for (int s = 0; s < D; s++) begin
            tap_chk(3'(s), (s == 0) ? 4'hC : (s == 1) ? 4'hB : (s == 2) ? 4'hA : 4'h0,
                    (s < 3) ? 1'b1 : 1'b0, "sweep");
        end

        // CE gaps between shifts.
        CLR = 1'b1; step(); CLR = 1'b0;
        shift(4'd5); step(); step();
        shift(4'd6); step();
        chk("gap_cnt", 32'(fill_cnt), 32'd2);
        tap_chk(3'd0, 4'd6, 1'b1, "gap_tap0");
        tap_chk(3'd1, 4'd5, 1'b1, "gap_tap1");
        tap_chk(3'd2, 4'd0, 1'b0, "gap_tap2");
        for (int i = 0; i < 6; i++) begin
            step();
            shift(W'(i));
        end
        chk("gap_dout", 32'(Dout), 32'd5);
        chk("gap_full", 32'(full), 32'd1);

        // CLR beats CE on a full buffer.
        CE = 1'b1; CLR = 1'b1; Din = 4'hF;
        step();
        CE = 1'b0; CLR = 1'b0;
        chk("clr_cnt", 32'(fill_cnt), 32'd0);
        chk("clr_full", 32'(full), 32'd0);
        chk("clr_dout", 32'(Dout), 32'd0);
        tap_chk(3'd0, 4'd0, 1'b0, "clr_tap0");

        // Asynchronous reset between edges.
        for (int d = 1; d <= 4; d++) shift(W'(d));
        tap_sel = 3'd3;
        #1 RST = 1'b0;
        #1;
        chk("arst_dout", 32'(Dout), 32'd0);
        chk("arst_cnt", 32'(fill_cnt), 32'd0);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_sel", 32'(selected_out), 32'd0);
        chk("arst_vld", 32'(tap_valid), 32'd0);
        step();
        RST = 1'b1;
        shift(4'd7);
        chk("post_cnt", 32'(fill_cnt), 32'd1);
        tap_chk(3'd0, 4'd7, 1'b1, "post_tap0");

        // Non power-of-two depth instance.
        for (int d = 1; d <= 5; d++) begin
            ce5 = 1'b1; din5 = 3'(d);
            step();
        end
        ce5 = 1'b0;
        chk("d5_dout", 32'(dout5), 32'd1);
        chk("d5_full", 32'(full5), 32'd1);
        chk("d5_cnt", 32'(cnt5), 32'd5);
        tap5_chk(3'd6, 3'd0, 1'b0, "d5_tap6");
        tap5_chk(3'd5, 3'd0, 1'b0, "d5_tap5");
        tap5_chk(3'd4, 3'd1, 1'b1, "d5_tap4");
        tap5_chk(3'd0, 3'd5, 1'b1, "d5_tap0");

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tapped_shift_reg.md
# tapped_shift_reg

Parametrised tapped delay line: DEPTH stages of WIDTH-bit registers shifting on clock enable, with a run-time selectable tap, fill tracking and per-tap validity. It supersedes the fixed 8×4-bit selecting register in the datapath. It serves as the sample history buffer feeding the filter and correlator stages, where downstream logic must know whether a selected tap holds real data yet.

## Interface
- WIDTH, 4, data width per stage (≥1)
- DEPTH, 8, number of stages (≥2, need not be a power of two)
- SEL_W, $clog2(DEPTH), tap select width (derived, not overridden)
- CNT_W, $clog2(DEPTH+1), fill counter width (derived)

- CLK  in  1  single clock, rising edge
- RST  in  1  reset, asynchronous assert, active-low; clears all state
- CE  in  1  shift enable
- CLR  in  1  synchronous clear of all stages and fill count
- Din  in  WIDTH  data into stage 0
- tap_sel  in  SEL_W  stage index presented on selected_out
- Dout  out  WIDTH  stage DEPTH-1 (oldest sample)
- selected_out  out  WIDTH  content of stage tap_sel
- tap_valid  out  1  stage tap_sel holds a sample written since the last reset/clear
- fill_cnt  out  CNT_W  number of valid stages, saturating at DEPTH
- full  out  1  fill_cnt == DEPTH

## Operation
- Reset (RST=0): every stage = 0, fill_cnt = 0. Outputs: Dout=0, selected_out=0, tap_valid=0, fill_cnt=0, full=0. Reset takes effect immediately, including mid-shift.
- Shift: on a rising CLK edge with CE=1 and CLR=0, stage[0] ← Din and stage[i] ← stage[i-1] for i=1..DEPTH-1. The old stage[DEPTH-1] is discarded.
- Hold: CE=0 and CLR=0 → all stages and fill_cnt unchanged.
- Clear: CLR=1 on an edge → stages = 0 and fill_cnt = 0. CLR has priority over CE; the Din of that cycle is not captured.
- Fill tracking: each shift increments fill_cnt until it reaches DEPTH, then it saturates. full = (fill_cnt == DEPTH).
- Tap select: selected_out = stage[tap_sel], tap_valid = (fill_cnt > tap_sel).
- Out-of-range tap (tap_sel ≥ DEPTH, only possible when DEPTH is not a power of two): selected_out = 0, tap_valid = 0. No error state.
- Stage data is never masked by validity. Invalid stages read as 0 after reset/clear because they were zeroed.

## Timing
- Din to stage k: k+1 CE-qualified edges. Din reaches Dout after DEPTH shifting edges.
- Without the macro, selected_out and tap_valid are combinational from tap_sel and the stage registers. They change in the same cycle as tap_sel, with zero latency.
- fill_cnt and full are registered and update on the same edge as the shift.
- CE gaps stretch latency in edges but never lose or duplicate data.
- RST deassertion is synchronised externally. The first edge after release can shift.

## Configuration
- TAPPED_SHIFT_REG_OUT_REG_EN defined: selected_out and tap_valid are registered, sampling stage[tap_sel] and validity on every CLK edge regardless of CE.
  - Registered outputs are 0 on reset and on CLR.
  - tap_sel to output latency becomes 1 cycle.
  - The output reflects the stage contents before that edge's shift.
- Undefined: combinational tap path as described above. Dout, fill_cnt and full are identical in both builds.

## Test plan
With WIDTH=4, DEPTH=8 unless stated:
- Reset, then CE=1 with Din=1,2,…,8 on 8 edges → Dout=1, stage7..0 = 1..8, fill_cnt=8, full=1. A 9th shift with Din=9 → Dout=2, fill_cnt stays 8.
- After 3 shifts (Din=A,B,C), sweep tap_sel 0..7 → selected_out = C,B,A,0,0,0,0,0 and tap_valid=1 only for tap_sel 0..2. Macro build shows the same values one cycle later.
- Interleave CE=0 cycles between shifts of 5,6 → stage values hold across gaps, fill_cnt advances only on CE edges, Dout sequence is unchanged versus a gapless run.
- Full buffer, CE=1 and CLR=1 with Din=F on the same edge → all stages 0, fill_cnt=0, full=0, tap_valid=0. F does not appear at stage 0.
- Assert RST mid-cycle after 4 shifts, between edges → all outputs 0 immediately without a clock edge. After release, a shift of Din=7 gives stage0=7 and fill_cnt=1.
- DEPTH=5, WIDTH=3, tap_sel=6 after 5 shifts → selected_out=0 and tap_valid=0. tap_sel=4 → oldest sample with tap_valid=1.
